// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default widths, control-bundle field offsets, no-op control.
package pipe_stage_reg_pkg;

   localparam int unsigned PC_W_DEF   = 32;
   localparam int unsigned CTRL_W_DEF = 18;

   // Control bundle layout, MSB first: regW, memToReg, memR, memW, ALUsrc, ALUOp[2:0], funct3[2:0], funct7[6:0]
   localparam int unsigned CTRL_REGW_BIT     = 17;
   localparam int unsigned CTRL_MEMTOREG_BIT = 16;
   localparam int unsigned CTRL_MEMR_BIT     = 15;
   localparam int unsigned CTRL_MEMW_BIT     = 14;
   localparam int unsigned CTRL_ALUSRC_BIT   = 13;
   localparam int unsigned CTRL_ALUOP_LSB    = 10;
   localparam int unsigned CTRL_ALUOP_W      = 3;
   localparam int unsigned CTRL_FUNCT3_LSB   = 7;
   localparam int unsigned CTRL_FUNCT3_W     = 3;
   localparam int unsigned CTRL_FUNCT7_LSB   = 0;
   localparam int unsigned CTRL_FUNCT7_W     = 7;

   // All-zero control is a bubble: no register write, no memory access
   localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline entry: valid bit, payload and control, with load and clear.
// Clear drops the entry and zeroes control; the payload keeps its stale value.
module pipe_skid_entry
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned PW = 1,
   parameter int unsigned CW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          load_i,
   input  logic [PW-1:0] pay_i,
   input  logic [CW-1:0] ctrl_i,
   output logic          valid_o,
   output logic [PW-1:0] pay_o,
   output logic [CW-1:0] ctrl_o
);

   logic          valid_q;
   logic [PW-1:0] pay_q;
   logic [CW-1:0] ctrl_q;

   // Entry storage; clear wins over load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         pay_q   <= '0;
         ctrl_q  <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pay_q   <= pay_i;
         ctrl_q  <= ctrl_i;
      end
   end

   assign valid_o = valid_q;
   assign pay_o   = pay_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned PC_W   = PC_W_DEF,
   parameter int unsigned DATA_W = 101,
   parameter int unsigned CTRL_W = CTRL_W_DEF,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam int unsigned PAY_W = PC_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              m_valid, s_valid;
   logic [PAY_W-1:0]  m_pay, s_pay, in_pay, m_pay_d;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_d;
   logic              m_load, m_clr, s_load, s_clr;
   logic              s_valid_d;
   logic              in_fire_c, take_c;
   logic              in_ready_q;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign in_pay    = {in_pc, in_data};
   assign in_fire_c = in_valid & in_ready_q;
   assign take_c    = ~m_valid | out_ready;

   // Steering of main/skid updates; flush, then refill of main, then parking in skid
   always_comb begin
      m_load    = 1'b0;
      m_clr     = 1'b0;
      s_load    = 1'b0;
      s_clr     = 1'b0;
      m_pay_d   = in_pay;
      m_ctrl_d  = in_ctrl;
      s_valid_d = s_valid;
      if (flush) begin
         m_clr     = 1'b1;
         s_clr     = 1'b1;
         s_valid_d = 1'b0;
      end else if (take_c) begin
         if (s_valid) begin
            m_load    = 1'b1;
            m_pay_d   = s_pay;
            m_ctrl_d  = s_ctrl;
            s_clr     = 1'b1;
            s_valid_d = 1'b0;
         end else if (in_fire_c) begin
            m_load = 1'b1;
         end else begin
            m_clr = 1'b1;
         end
      end else if (in_fire_c) begin
         s_load    = 1'b1;
         s_valid_d = 1'b1;
      end
   end

   pipe_skid_entry #(.PW(PAY_W), .CW(CTRL_W)) u_main (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (m_clr),
      .load_i  (m_load),
      .pay_i   (m_pay_d),
      .ctrl_i  (m_ctrl_d),
      .valid_o (m_valid),
      .pay_o   (m_pay),
      .ctrl_o  (m_ctrl)
   );

   pipe_skid_entry #(.PW(PAY_W), .CW(CTRL_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (s_clr),
      .load_i  (s_load),
      .pay_i   (in_pay),
      .ctrl_i  (in_ctrl),
      .valid_o (s_valid),
      .pay_o   (s_pay),
      .ctrl_o  (s_ctrl)
   );

   // Ready is its own flop so upstream sees no path from out_ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) in_ready_q <= 1'b1;
      else      in_ready_q <= ~s_valid_d;
   end

   // Stall counter next value: clear wins, otherwise saturating count of stalled cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_clr)
         stall_cnt_d = '0;
      else if (m_valid & ~out_ready & ~flush & (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // Stall counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign in_ready  = in_ready_q;
   assign out_valid = m_valid;
   assign out_pc    = m_pay[PAY_W-1:DATA_W];
   assign out_data  = m_pay[DATA_W-1:0];
   assign out_ctrl  = m_ctrl;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios then random traffic,
// compared against a two-deep FIFO reference model.
module tb_pipe_stage_reg;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned DATA_W = 101;
   localparam int unsigned CTRL_W = 18;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned CNT_SAT = 15;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] data;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;
   logic              stall_clr;

   int n_vec = 0;
   int n_err = 0;

   entry_t      q[$];
   int unsigned exp_cnt = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PC_W(PC_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .stall_cnt (stall_cnt),
      .stall_clr (stall_clr)
   );

   task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      n_vec++;
      assert (got === want)
      else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Compare every visible output against the reference model
   task automatic check_model(input string tag);
      entry_t h;
      logic   ev;
      ev = (q.size() != 0);
      expect_eq({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
      expect_eq({tag, ".in_ready"},  128'(in_ready),  128'(q.size() < 2));
      expect_eq({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(exp_cnt));
      if (ev) begin
         h = q[0];
         expect_eq({tag, ".out_pc"},   128'(out_pc),   128'(h.pc));
         expect_eq({tag, ".out_data"}, 128'(out_data), 128'(h.data));
         expect_eq({tag, ".out_ctrl"}, 128'(out_ctrl), 128'(h.ctrl));
      end else begin
         expect_eq({tag, ".out_ctrl_bubble"}, 128'(out_ctrl), 128'(0));
      end
   endtask

   // Reference behaviour at a rising edge: two-deep FIFO, flush empties it
   task automatic model_edge();
      int unsigned n;
      logic        acc;
      entry_t      e;
      n = q.size();
      if (stall_clr) exp_cnt = 0;
      else if (n > 0 && !out_ready && !flush && exp_cnt < CNT_SAT) exp_cnt = exp_cnt + 1;
      if (flush) begin
         q.delete();
      end else begin
         acc = in_valid && (n < 2);
         e.pc = in_pc; e.data = in_data; e.ctrl = in_ctrl;
         if (n > 0 && out_ready) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
   endtask

   task automatic step(input string tag, input logic fl, input logic iv,
                       input logic [PC_W-1:0] pc, input logic ordy, input logic clr);
      logic [127:0] r;
      @(negedge clk);
      r = {$urandom, $urandom, $urandom, $urandom};
      flush     = fl;
      in_valid  = iv;
      in_pc     = pc;
      in_data   = r[DATA_W-1:0];
      in_ctrl   = CTRL_W'($urandom_range(1, (1 << CTRL_W) - 1));
      out_ready = ordy;
      stall_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
      in_ctrl = '0; out_ready = 1'b0; stall_clr = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      expect_eq("rst.out_valid", 128'(out_valid), 128'(0));
      expect_eq("rst.in_ready",  128'(in_ready),  128'(1));
      expect_eq("rst.out_pc",    128'(out_pc),    128'(0));
      expect_eq("rst.out_data",  128'(out_data),  128'(0));
      expect_eq("rst.out_ctrl",  128'(out_ctrl),  128'(0));
      expect_eq("rst.stall_cnt", 128'(stall_cnt), 128'(0));
      @(negedge clk);
      rst = 1'b1;

      // Streaming: one transfer per cycle
      for (int i = 0; i < 8; i++) step("stream", 1'b0, 1'b1, PC_W'(i * 4), 1'b1, 1'b0);
      expect_eq("stream.last_pc", 128'(out_pc), 128'(32'h1C));
      step("drain", 1'b0, 1'b0, '0, 1'b1, 1'b1);

      // Back-pressure with skid fill
      step("bp", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
      step("bp", 1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
      step("bp", 1'b0, 1'b0, 32'h48, 1'b0, 1'b0);
      step("bp", 1'b0, 1'b0, 32'h48, 1'b0, 1'b0);
      expect_eq("bp.out_pc",    128'(out_pc),    128'(32'h40));
      expect_eq("bp.in_ready",  128'(in_ready),  128'(0));
      expect_eq("bp.stall_cnt", 128'(stall_cnt), 128'(3));
      step("bp_rel", 1'b0, 1'b0, '0, 1'b1, 1'b0);
      expect_eq("bp_rel.pc44", 128'(out_pc), 128'(32'h44));
      step("bp_rel", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Flush with main and skid full, incoming entry dropped
      step("fl_fill", 1'b0, 1'b1, 32'h60, 1'b0, 1'b0);
      step("fl_fill", 1'b0, 1'b1, 32'h64, 1'b0, 1'b0);
      step("flush", 1'b1, 1'b1, 32'h80, 1'b0, 1'b0);
      expect_eq("flush.out_valid", 128'(out_valid), 128'(0));
      expect_eq("flush.out_ctrl",  128'(out_ctrl),  128'(0));
      expect_eq("flush.in_ready",  128'(in_ready),  128'(1));
      step("post_fl", 1'b0, 1'b0, '0, 1'b1, 1'b0);
      step("post_fl", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Simultaneous in_fire and out_fire
      step("simul", 1'b0, 1'b1, 32'hFC, 1'b1, 1'b0);
      step("simul", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      expect_eq("simul.out_pc", 128'(out_pc), 128'(32'h100));

      // Stall counter saturation and clear
      step("sat", 1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) step("sat", 1'b0, 1'b0, '0, 1'b0, 1'b0);
      expect_eq("sat.stall_cnt", 128'(stall_cnt), 128'(CNT_SAT));
      step("sat_clr", 1'b0, 1'b1, 32'h204, 1'b0, 1'b1);
      expect_eq("sat_clr.stall_cnt", 128'(stall_cnt), 128'(0));
      step("hold2", 1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Asynchronous reset mid-stream with two entries held
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      expect_eq("arst.out_valid", 128'(out_valid), 128'(0));
      expect_eq("arst.in_ready",  128'(in_ready),  128'(1));
      expect_eq("arst.out_ctrl",  128'(out_ctrl),  128'(0));
      expect_eq("arst.stall_cnt", 128'(stall_cnt), 128'(0));
      q.delete();
      exp_cnt = 0;
      @(negedge clk);
      rst = 1'b1;
      step("post_rst", 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom_range(0, 15) == 0), 1'($urandom), PC_W'($urandom) & ~PC_W'(3),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
